counter_configurable: RTL and testbench
=======================================

# counter_configurable

Parametrised successor to the 4-bit enable counter in the board designs. Provides WIDTH-bit up/down counting with a programmable limit, wrap or saturate mode, synchronous clear and load, and a registered terminal-count pulse. An optional prescaler is selected at compile time. The block sits between board-level control inputs and the count outputs, with the same clock and reset as its predecessor.

## Interface
- Parameters:
  - WIDTH, default 4: counter width in bits, minimum 2.
  - PRESCALE_W, default 8: prescaler divisor width. Used only with COUNTER_PRESCALE_EN.
- Ports:
  - clock_i, input, 1: single clock, rising edge.
  - reset_n_i, input, 1: asynchronous, active-low reset.
  - enable_i, input, 1: count enable.
  - clear_i, input, 1: synchronous clear to 0.
  - load_i, input, 1: synchronous load.
  - load_value_i, input, WIDTH: value loaded on load_i.
  - up_i, input, 1: count direction; 1 = up, 0 = down.
  - saturate_i, input, 1: boundary mode; 1 = saturate, 0 = wrap.
  - limit_i, input, WIDTH: upper count boundary, inclusive.
  - prescale_div_i, input, PRESCALE_W: prescaler divisor minus 1. Present only with COUNTER_PRESCALE_EN.
  - counter_value_o, output, WIDTH: registered count.
  - terminal_o, output, 1: registered one-cycle boundary pulse.

## Operation
- Priority is clear_i > load_i > count step. Only one action is taken per cycle.
- A count step occurs when enable_i=1, tick=1, clear_i=0 and load_i=0. Without the prescaler, tick is constant 1.
- Counting up:
  - value < limit_i → value+1.
  - value ≥ limit_i, wrap mode → 0.
  - value ≥ limit_i, saturate mode → limit_i.
- Counting down:
  - value ≠ 0 → value−1.
  - value = 0, wrap mode → limit_i.
  - value = 0, saturate mode → hold at 0.
- A boundary event is a count step taken while value is at the boundary for the current direction: ≥ limit_i when up, 0 when down.
- terminal_o is 1 in the cycle after a boundary event and 0 otherwise. It fires on every boundary step, including repeated steps while saturated.
- load_value_i greater than limit_i is loaded unchanged. The next up-step is then a boundary event.
- limit_i, up_i and saturate_i may change on any cycle and take effect on the next step. limit_i = 0 makes every up-step a boundary event.
- Arithmetic is modulo 2^WIDTH. There is no carry output.
- clear_i and load_i do not assert terminal_o.

## Timing
- Reset values: counter_value_o = 0, terminal_o = 0, prescaler count = 0.
- Reset assertion takes effect asynchronously. Deassertion is used synchronously; the first step can occur on the first rising edge after release.
- Latency is 1 cycle from a qualifying input to counter_value_o. terminal_o updates on the same edge as the boundary step.
- There is no combinational path from any input to any output.
- Reset asserted mid-count discards all state, including a pending terminal_o.

## Configuration
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - An internal PRESCALE_W-bit prescaler counts cycles where enable_i=1.
  - tick=1 when prescaler = prescale_div_i; the prescaler then returns to 0.
  - clear_i or load_i resets the prescaler to 0.
  - prescale_div_i = 0 means a step on every enabled cycle.
  - The prescaler holds its value while enable_i=0.
- Undefined: the prescale_div_i port and prescaler logic are absent, and tick=1.

## Structure
- Package counter_pkg:
  - count_dir_e: COUNT_DOWN=0, COUNT_UP=1.
  - bound_mode_e: MODE_WRAP=0, MODE_SATURATE=1.
  - Constant COUNTER_MIN_WIDTH=2.
- Sub-module counter_prescaler: instantiated only under COUNTER_PRESCALE_EN.
  - Parameter: PRESCALE_W.
  - Ports: clock_i, reset_n_i, enable_i, restart_i, div_i, tick_o.

## Test plan
- Reset then enable_i=1, up, wrap, limit_i=9, 12 cycles → counter_value_o runs 1..9, 0, 1, 2. terminal_o pulses once, the cycle value becomes 0.
- Down, saturate, load_value_i=2, then 4 enabled cycles → 1, 0, 0, 0. terminal_o high in the last 2 cycles.
- Down, wrap, limit_i=5, value 0, one step → value 5 and terminal_o=1.
- load_i=1 with load_value_i=14, limit_i=9; next up, wrap step → value 0 and terminal_o=1. Same case with clear_i=1 and load_i=1 together → value 0 and terminal_o=0.
- reset_n_i pulsed low mid-cycle with value 7 → counter_value_o=0 before the next edge, and terminal_o=0.
- COUNTER_PRESCALE_EN, prescale_div_i=3, enable_i=1, 12 cycles → value steps every 4th cycle and reaches 3. Dropping enable_i for 2 cycles delays the next step by 2 cycles.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the configurable up/down counter.
// Direction and boundary-mode enums mirror the single-bit control inputs.
package counter_pkg;

  typedef enum logic {
    COUNT_DOWN = 1'b0,
    COUNT_UP   = 1'b1
  } count_dir_e;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } bound_mode_e;

  localparam int unsigned COUNTER_MIN_WIDTH = 2;

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated cycle divider: tick_o marks the enabled cycle on which the count equals div_i.
// Count returns to 0 after the tick; restart_i forces 0; disabled cycles hold the count.
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic                  restart_i,
  input  logic [PRESCALE_W-1:0] div_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;
  logic                  at_div;

  assign at_div = (count_q == div_i);
  assign tick_o = enable_i & at_div;

  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = at_div ? '0 : count_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/counter_configurable.sv
// WIDTH-bit up/down counter with limit, wrap/saturate, clear/load and registered terminal pulse; 1-cycle latency.
// Optional enable-gated prescaler when COUNTER_PRESCALE_EN is defined.
module counter_configurable
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_value_i,
  input  logic                  up_i,
  input  logic                  saturate_i,
  input  logic [WIDTH-1:0]      limit_i,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div_i,
`endif
  output logic [WIDTH-1:0]      counter_value_o,
  output logic                  terminal_o
);

  generate
    if (WIDTH < COUNTER_MIN_WIDTH || PRESCALE_W < 1) begin : g_bad_cfg
      $error("counter_configurable: WIDTH must be >= 2 and PRESCALE_W >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;
  logic             terminal_q;
  logic             terminal_d;
  logic             tick;
  logic             step;
  logic             at_bound;
  count_dir_e       dir;
  bound_mode_e      mode;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .enable_i  (enable_i),
    .restart_i (clear_i | load_i),
    .div_i     (prescale_div_i),
    .tick_o    (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign dir  = count_dir_e'(up_i);
  assign mode = bound_mode_e'(saturate_i);
  assign step = enable_i & tick & ~clear_i & ~load_i;

  // Values loaded above the limit count as already at the upper boundary.
  assign at_bound = (dir == COUNT_UP) ? (value_q >= limit_i) : (value_q == '0);

  always_comb begin
    value_d    = value_q;
    terminal_d = 1'b0;
    if (clear_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = load_value_i;
    end else if (step) begin
      terminal_d = at_bound;
      if (dir == COUNT_UP) begin
        if (!at_bound) begin
          value_d = value_q + WIDTH'(1);
        end else if (mode == MODE_SATURATE) begin
          value_d = limit_i;
        end else begin
          value_d = '0;
        end
      end else begin
        if (!at_bound) begin
          value_d = value_q - WIDTH'(1);
        end else if (mode == MODE_SATURATE) begin
          value_d = '0;
        end else begin
          value_d = limit_i;
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      value_q    <= '0;
      terminal_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      terminal_q <= terminal_d;
    end
  end

  assign counter_value_o = value_q;
  assign terminal_o      = terminal_q;

endmodule

// File: tb/tb_counter_configurable.sv
// Directed self-checking bench for counter_configurable (prescaler section built only with COUNTER_PRESCALE_EN).
module tb_counter_configurable;

  localparam int W  = 4;
  localparam int PW = 8;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          clear;
  logic          load;
  logic [W-1:0]  load_value;
  logic          up;
  logic          sat;
  logic [W-1:0]  limit;
  logic [PW-1:0] prescale_div;
  logic [W-1:0]  value;
  logic          term;

  int checks = 0;
  int errors = 0;

  counter_configurable #(
    .WIDTH      (W),
    .PRESCALE_W (PW)
  ) dut (
    .clock_i         (clk),
    .reset_n_i       (rst_n),
    .enable_i        (enable),
    .clear_i         (clear),
    .load_i          (load),
    .load_value_i    (load_value),
    .up_i            (up),
    .saturate_i      (sat),
    .limit_i         (limit),
`ifdef COUNTER_PRESCALE_EN
    .prescale_div_i  (prescale_div),
`endif
    .counter_value_o (value),
    .terminal_o      (term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input int exp_val, input int exp_term);
    chk({tag, "_value"}, int'(value), exp_val);
    chk({tag, "_term"}, int'(term), exp_term);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    clear        = 1'b0;
    load         = 1'b0;
    load_value   = '0;
    up           = 1'b1;
    sat          = 1'b0;
    limit        = 4'd9;
    prescale_div = '0;

    #3;
    chk_both("reset", 0, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Up, wrap, limit 9: 1..9, 0, 1, 2 with terminal on the wrap
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_both($sformatf("up_wrap_%0d", i), i % 10, (i == 10) ? 1 : 0);
    end

    // Down, saturate from 2: 1, 0, 0, 0 with terminal on the last two
    up = 1'b0; sat = 1'b1; load = 1'b1; load_value = 4'd2;
    step();
    chk_both("load2", 2, 0);
    load = 1'b0;
    step(); chk_both("down_sat_1", 1, 0);
    step(); chk_both("down_sat_2", 0, 0);
    step(); chk_both("down_sat_3", 0, 1);
    step(); chk_both("down_sat_4", 0, 1);

    // Down, wrap from 0 to limit 5
    sat = 1'b0; limit = 4'd5;
    step(); chk_both("down_wrap", 5, 1);

    // Load above limit, next up step is a boundary
    limit = 4'd9; load = 1'b1; load_value = 4'd14;
    step(); chk_both("load14", 14, 0);
    load = 1'b0; up = 1'b1;
    step(); chk_both("over_limit_wrap", 0, 1);

    // Clear beats load, no terminal
    load = 1'b1; load_value = 4'd14;
    step(); chk_both("load14_again", 14, 0);
    clear = 1'b1;
    step(); chk_both("clear_and_load", 0, 0);
    clear = 1'b0; load = 1'b0;
    step(); chk_both("after_clear", 1, 0);

    // Up saturate at limit 3, repeated terminal; then limit 0
    sat = 1'b1; limit = 4'd3; load = 1'b1; load_value = 4'd3;
    step(); chk_both("load3", 3, 0);
    load = 1'b0;
    step(); chk_both("up_sat_1", 3, 1);
    step(); chk_both("up_sat_2", 3, 1);
    limit = 4'd0;
    step(); chk_both("limit0_sat", 0, 1);
    sat = 1'b0;
    step(); chk_both("limit0_wrap", 0, 1);

    // Disabled counter holds and terminal drops
    enable = 1'b0;
    step(); chk_both("hold", 0, 0);
    enable = 1'b1;

    // Async reset mid-cycle at value 7 with a pending terminal
    limit = 4'd7; sat = 1'b1; load = 1'b1; load_value = 4'd7;
    step(); chk_both("load7", 7, 0);
    load = 1'b0;
    step(); chk_both("sat7", 7, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_both("async_reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    step(); chk_both("post_reset", 0, 0);

`ifdef COUNTER_PRESCALE_EN
    // Divide by 4: a step on every 4th enabled cycle
    prescale_div = 8'd3; limit = 4'd9; sat = 1'b0; up = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_both($sformatf("prescale_%0d", i), i / 4, 0);
    end
    enable = 1'b0;
    step(); chk_both("prescale_off_1", 3, 0);
    step(); chk_both("prescale_off_2", 3, 0);
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_both($sformatf("prescale_resume_%0d", i), (i == 4) ? 4 : 3, 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
